// File: rtl/cpu_pkg.sv
// Shared types and widths for the 16-bit core pipeline.
//   DATA_W     : register / memory data width
//   REG_ADR_W  : register-file address width
//   wb_state_t : load-wait controller states
//   mem_wb_t   : contents of the MEM/WB pipeline register
package cpu_pkg;

  localparam int DATA_W    = 16;
  localparam int REG_ADR_W = 3;

  typedef enum logic {
    WB_IDLE = 1'b0,
    WB_WAIT = 1'b1
  } wb_state_t;

  typedef struct packed {
    logic                 valid;
    logic                 regwrite_en;
    logic [REG_ADR_W-1:0] regwrite_adr;
    logic [DATA_W-1:0]    regwrite_dat;
    logic                 is_load;
    logic                 halt;
  } mem_wb_t;

  // A bubble carries no valid instruction and never writes or halts.
  localparam mem_wb_t MEM_WB_BUBBLE = '0;

endpackage

// File: rtl/load_wait_ctrl.sv
// Load wait controller: holds the upstream pipeline while a load waits for
// main-memory read data that takes more than one cycle to arrive.
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   WB_IDLE | no load outstanding; a new valid load may start a wait
//   WB_WAIT | load held in MEM; cnt counts the remaining stall cycles
//
// Ports:
//   clk, reset_n       clock, asynchronous active-low reset
//   valid_mem          MEM stage holds a real instruction
//   memread_mem        MEM instruction is a load
//   flush              synchronous abort of any wait in progress
//   main_mem_waiting   stall request to IF/ID/EX/MEM
module load_wait_ctrl
  import cpu_pkg::*;
#(
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 3
) (
  input  logic clk,
  input  logic reset_n,
  input  logic valid_mem,
  input  logic memread_mem,
  input  logic flush,
  output logic main_mem_waiting
);

  // The first stall cycle is spent in IDLE, so the counter only has to
  // cover the remaining LOAD_LAT-2 cycles.
  localparam bit               STALLS   = (LOAD_LAT > 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = (LOAD_LAT > 1) ? CNT_W'(LOAD_LAT - 2) : '0;

  wb_state_t        state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             load_start;
  logic             wait_req;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= WB_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    wait_req   = 1'b0;
    load_start = valid_mem & memread_mem & (state == WB_IDLE);

    case (state)
      WB_IDLE: begin
        if (load_start && STALLS) begin
          wait_req  = 1'b1;
          state_nxt = WB_WAIT;
          cnt_nxt   = CNT_LOAD;
        end
      end
      WB_WAIT: begin
        if (cnt != '0) begin
          wait_req = 1'b1;
          cnt_nxt  = cnt - CNT_W'(1);
        end else begin
          state_nxt = WB_IDLE;
        end
      end
      default: state_nxt = WB_IDLE;
    endcase

    // The stall request itself is not masked by flush: an aborted wait
    // releases the pipeline on the following cycle.
    if (flush) begin
      state_nxt = WB_IDLE;
      cnt_nxt   = '0;
    end
  end

  // In reset the state is already IDLE, but a load sitting in MEM would
  // still raise load_start, so the request is masked explicitly.
  assign main_mem_waiting = wait_req & reset_n;

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register and write-back data selector.
// Loads complete here by selecting synchronous main-memory read data; the
// load_wait_ctrl instance stalls upstream stages for slow memory.
//
// Ports:
//   clk, reset_n             clock, asynchronous active-low reset
//   valid_mem                MEM stage holds a real instruction
//   regwrite_dat_mem/en/adr  register-write data, enable, destination
//   memread_mem              instruction is a load
//   halt_mem                 instruction is HLT
//   flush                    synchronous squash of MEM/WB and the wait FSM
//   main_mem_read_dat        synchronous memory read data
//   main_mem_waiting         stall request to IF/ID/EX/MEM
//   valid_wb                 WB holds a real instruction
//   regwrite_en/adr/dat_wb   register-file write port (dat also forwards)
//   halt_wb                  HLT has reached WB
module mem_wb_stage
  import cpu_pkg::*;
#(
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 3
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 valid_mem,
  input  logic [DATA_W-1:0]    regwrite_dat_mem,
  input  logic                 regwrite_en_mem,
  input  logic [REG_ADR_W-1:0] regwrite_adr_mem,
  input  logic                 memread_mem,
  input  logic                 halt_mem,
  input  logic                 flush,
  input  logic [DATA_W-1:0]    main_mem_read_dat,
  output logic                 main_mem_waiting,
  output logic                 valid_wb,
  output logic                 regwrite_en_wb,
  output logic [REG_ADR_W-1:0] regwrite_adr_wb,
  output logic [DATA_W-1:0]    regwrite_dat_wb,
  output logic                 halt_wb
);

  mem_wb_t wb_q, wb_d;

  load_wait_ctrl #(
    .LOAD_LAT (LOAD_LAT),
    .CNT_W    (CNT_W)
  ) u_load_wait_ctrl (
    .clk              (clk),
    .reset_n          (reset_n),
    .valid_mem        (valid_mem),
    .memread_mem      (memread_mem),
    .flush            (flush),
    .main_mem_waiting (main_mem_waiting)
  );

  always_comb begin
    wb_d = MEM_WB_BUBBLE;
    if (!flush && !main_mem_waiting) begin
      wb_d.valid        = valid_mem;
      wb_d.regwrite_en  = regwrite_en_mem & valid_mem;
      wb_d.regwrite_adr = regwrite_adr_mem;
      wb_d.regwrite_dat = regwrite_dat_mem;
      wb_d.is_load      = memread_mem;
      wb_d.halt         = halt_mem & valid_mem;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wb_q <= MEM_WB_BUBBLE;
    end else begin
      wb_q <= wb_d;
    end
  end

  assign valid_wb        = wb_q.valid;
  assign regwrite_en_wb  = wb_q.regwrite_en;
  assign regwrite_adr_wb = wb_q.regwrite_adr;
  assign halt_wb         = wb_q.halt;

  // Memory data is valid in exactly the cycle a load sits in WB.
  assign regwrite_dat_wb = wb_q.is_load ? main_mem_read_dat : wb_q.regwrite_dat;

endmodule
